// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
//
// Shared definitions for the multicycle MIPS-subset controller:
//   - opcode / funct field constants
//   - ALU operation codes (5-bit, zero-extended to ALUOP_W at the consumers)
//   - alu_src_b and pc_source mux encodings
//   - FSM state enum. S_TRAP exists only when MULTICYCLE_CONTROL_TRAP_EN is
//     defined.
//   - packed control-word struct used inside the controller
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Native width of the ALU operation code
    localparam int ALU_CODE_W = 5;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_LUI  = 5'd7,
        ALU_ADDU = 5'd8,
        ALU_SUBU = 5'd9
    } alu_code_e;

    // ALU operand B select
    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,  // register B
        SRCB_FOUR   = 2'b01,  // constant 4 (PC increment)
        SRCB_IMM    = 2'b10,  // extended immediate
        SRCB_IMM_SH = 2'b11   // extended immediate << 2 (branch offset)
    } src_b_e;

    // PC source select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00, // ALU result (PC + 4)
        PCSRC_ALUOUT = 2'b01, // ALUOut register (branch target)
        PCSRC_JUMP   = 2'b10  // jump target
    } pc_src_e;

    // FSM states; FETCH must stay at zero so the reset state reads as 0
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_R_WB     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } state_e;

    // Per-state control word (everything except alu_op, whose width is a
    // parameter of the controller)
    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        logic    branch_ne;
        logic    i_or_d;
        logic    ir_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem2reg;
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src_a;
        src_b_e  alu_src_b;
        pc_src_e pc_source;
        logic    ext_op;
        logic    instr_done;
    } ctrl_t;

    function automatic logic is_rtype(input logic [5:0] opcode);
        return opcode == OP_RTYPE;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_dec.sv
// ----------------------------------------------------------------------------
// control_alu_dec
//
// Combinational ALU-operation decoder. Maps opcode/funct to the ALU code the
// instruction uses in its execute and write-back states, and flags
// instructions outside the supported subset.
//
// Ports:
//   opcode_i  [5:0]          instruction opcode field
//   funct_i   [5:0]          instruction funct field (R-type only)
//   alu_op_o  [ALUOP_W-1:0]  ALU code, zero-extended to ALUOP_W
//   illegal_o                opcode/funct not in the supported subset
// ----------------------------------------------------------------------------
module control_alu_dec #(
    parameter int ALUOP_W = 5  // must be >= 5
) (
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               illegal_o
);
    import multicycle_control_pkg::*;

    alu_code_e code;

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        code      = ALU_ADD;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  code = ALU_ADD;
                    FN_ADDU: code = ALU_ADDU;
                    FN_SUB:  code = ALU_SUB;
                    FN_SUBU: code = ALU_SUBU;
                    FN_SLL:  code = ALU_SLL;
                    FN_SRL:  code = ALU_SRL;
                    FN_SLT:  code = ALU_SLT;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_SLTI:        code = ALU_SLT;
            OP_ORI:         code = ALU_OR;
            OP_LUI:         code = ALU_LUI;
            OP_LW, OP_SW:   code = ALU_ADD;
            OP_BEQ, OP_BNE: code = ALU_SUB;
            OP_J:           code = ALU_ADD;
            default:        illegal_o = 1'b1;
        endcase
    end

    assign alu_op_o = ALUOP_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM of a multicycle MIPS-subset datapath. One instruction
// passes FETCH -> DECODE -> (execute / memory / branch / jump states) and
// back to FETCH; instr_done pulses in the last cycle of each retired
// instruction.
//
// Configuration macro: MULTICYCLE_CONTROL_TRAP_EN
//   defined   : illegal opcode/funct enters TRAP, trap_o held until
//               trap_ack_i, then FETCH without instr_done.
//   undefined : illegal instruction is a NOP retired from DECODE,
//               trap_o tied 0, no TRAP state.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode_i, funct_i       instruction-register fields
//   mem_ready_i             memory access completes in the cycle it is high
//   trap_ack_i              illegal-instruction trap acknowledge
//   pc_write_o .. ext_op_o  datapath control (see ctrl_t in the package)
//   alu_op_o [ALUOP_W-1:0]  ALU operation, zero-extended
//   instr_done_o            one-cycle pulse per retired instruction
//   trap_o                  illegal-instruction trap pending
//   state_o [3:0]           current FSM state (debug)
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALUOP_W = 5  // must be >= 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               mem_ready_i,
    input  logic               trap_ack_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               branch_ne_o,
    output logic               i_or_d_o,
    output logic               ir_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem2reg_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         pc_source_o,
    output logic               ext_op_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               instr_done_o,
    output logic               trap_o,
    output logic [3:0]         state_o
);
    import multicycle_control_pkg::*;

    state_e             state_q, state_d;
    // Cleared by reset, set on the first rising edge afterwards: keeps every
    // output low while rst_n is low and until that first edge.
    logic               run_q;
    ctrl_t              ctrl, ctrl_out;
    logic [ALUOP_W-1:0] alu_op;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_illegal;

    control_alu_dec #(
        .ALUOP_W (ALUOP_W)
    ) u_alu_dec (
        .opcode_i  (opcode_i),
        .funct_i   (funct_i),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        alu_op  = ALUOP_W'(ALU_ADD);

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                if (mem_ready_i) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.ext_op    = 1'b1;
                if (dec_illegal) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    state_d = S_TRAP;
`else
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
`endif
                end else begin
                    case (opcode_i)
                        OP_RTYPE:               state_d = S_EXEC_R;
                        OP_SLTI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                        OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                        OP_J:                   state_d = S_JUMP;
                        default:                state_d = S_FETCH;
                    endcase
                end
            end

            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                alu_op         = dec_alu_op;
                state_d        = S_R_WB;
            end

            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = (opcode_i != OP_ORI);
                alu_op         = dec_alu_op;
                state_d        = S_R_WB;
            end

            S_R_WB: begin
                // Shared by R-type (dest rd) and immediate ops (dest rt)
                ctrl.reg_dst    = is_rtype(opcode_i);
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                alu_op          = dec_alu_op;
                state_d         = S_FETCH;
            end

            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
                state_d        = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                ctrl.mem2reg    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end

            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready_i) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end
            end

            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode_i == OP_BNE);
                ctrl.instr_done    = 1'b1;
                alu_op             = ALUOP_W'(ALU_SUB);
                state_d            = S_FETCH;
            end

            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end

`ifdef MULTICYCLE_CONTROL_TRAP_EN
            S_TRAP: begin
                if (trap_ack_i) begin
                    state_d = S_FETCH;
                end
            end
`endif

            default: state_d = S_FETCH;
        endcase

        // First cycle after reset release: hold FETCH, no access yet
        if (!run_q) begin
            state_d = S_FETCH;
        end
    end

    assign ctrl_out = run_q ? ctrl : '0;

    assign pc_write_o      = ctrl_out.pc_write;
    assign pc_write_cond_o = ctrl_out.pc_write_cond;
    assign branch_ne_o     = ctrl_out.branch_ne;
    assign i_or_d_o        = ctrl_out.i_or_d;
    assign ir_write_o      = ctrl_out.ir_write;
    assign mem_read_o      = ctrl_out.mem_read;
    assign mem_write_o     = ctrl_out.mem_write;
    assign mem2reg_o       = ctrl_out.mem2reg;
    assign reg_dst_o       = ctrl_out.reg_dst;
    assign reg_write_o     = ctrl_out.reg_write;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign pc_source_o     = ctrl_out.pc_source;
    assign ext_op_o        = ctrl_out.ext_op;
    assign instr_done_o    = ctrl_out.instr_done;
    assign alu_op_o        = run_q ? alu_op : '0;
    assign state_o         = state_q;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
    // state_q is FETCH whenever run_q is low, so no extra gating needed
    assign trap_o = (state_q == S_TRAP);
`else
    logic unused_trap_ack;
    assign unused_trap_ack = trap_ack_i;
    assign trap_o          = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control (ALUOP_W = 6 to exercise the
// zero-extension of alu_op). Each instruction is run against a small memory
// responder with configurable wait states; the reference model predicts, per
// instruction class, the retire latency, how many cycles each strobe is high,
// and the key control values at the write/branch/execute points.
// ----------------------------------------------------------------------------
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int ALUOP_W = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [5:0]         opcode, funct;
    logic               mem_ready, trap_ack;
    logic               pc_write, pc_write_cond, branch_ne, i_or_d, ir_write;
    logic               mem_read, mem_write, mem2reg, reg_dst, reg_write;
    logic               alu_src_a, ext_op, instr_done, trap;
    logic [1:0]         alu_src_b, pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic [3:0]         state;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.ALUOP_W(ALUOP_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_i        (opcode),
        .funct_i         (funct),
        .mem_ready_i     (mem_ready),
        .trap_ack_i      (trap_ack),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_ne_o     (branch_ne),
        .i_or_d_o        (i_or_d),
        .ir_write_o      (ir_write),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem2reg_o       (mem2reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_source_o     (pc_source),
        .ext_op_o        (ext_op),
        .alu_op_o        (alu_op),
        .instr_done_o    (instr_done),
        .trap_o          (trap),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All outputs flattened (28 bits) for all-zero / X checks
    function automatic logic [31:0] outs_flat();
        return {4'b0, pc_write, pc_write_cond, branch_ne, i_or_d, ir_write, mem_read,
                mem_write, mem2reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                pc_source, ext_op, instr_done, trap, alu_op, state};
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_e;

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLL,
                    FN_SRL, FN_SLT, FN_AND, FN_OR: return K_R;
                    default: return K_ILL;
                endcase
            end
            OP_SLTI, OP_ORI, OP_LUI: return K_I;
            OP_LW:                   return K_LW;
            OP_SW:                   return K_SW;
            OP_BEQ, OP_BNE:          return K_BR;
            OP_J:                    return K_J;
            default:                 return K_ILL;
        endcase
    endfunction

    function automatic alu_code_e exp_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_SLTI) return ALU_SLT;
        if (op == OP_ORI)  return ALU_OR;
        if (op == OP_LUI)  return ALU_LUI;
        case (fn)
            FN_ADDU: return ALU_ADDU;
            FN_SUB:  return ALU_SUB;
            FN_SUBU: return ALU_SUBU;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            FN_SLT:  return ALU_SLT;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Runs one instruction starting just after the rising edge of its first
    // FETCH cycle; fw/dw = wait cycles on the fetch/data access, ack_delay =
    // cycles of trap before trap_ack.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int dw, input int ack_delay);
        kind_e      k        = classify(op, fn);
        bit         trap_en  = 1'b0;
        bit         ill_trap;
        bit         writes_reg;
        int         exp_lat;
        int         cyc      = 0;
        int         fw_left  = fw;
        int         dw_left  = dw;
        int         ack_left = ack_delay;
        int         done_cyc = 0;
        int         regw_cyc = 0;
        int         n_done = 0, n_regw = 0, n_memw = 0, n_pcw = 0, n_pcwc = 0;
        int         n_irw = 0, n_drd = 0, n_trap = 0;
        bit         done  = 1'b0;
        bit         saw_x = 1'b0;
        logic [31:0] regw_alu = '0;
        logic       regw_dst = 1'b0, regw_m2r = 1'b0, br_ne = 1'b0, ext_exec = 1'bx;
        logic [1:0] br_src = 2'b00;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
        trap_en = 1'b1;
`endif
        ill_trap   = (k == K_ILL) && trap_en;
        writes_reg = (k == K_R) || (k == K_I) || (k == K_LW);
        case (k)
            K_R, K_I:   exp_lat = 4 + fw;
            K_LW:       exp_lat = 5 + fw + dw;
            K_SW:       exp_lat = 4 + fw + dw;
            K_BR, K_J:  exp_lat = 3 + fw;
            default:    exp_lat = trap_en ? (3 + fw + ack_delay) : (2 + fw);
        endcase

        opcode = op;
        funct  = fn;
        while (!done && cyc < 60) begin
            cyc++;
            mem_ready = 1'b0;
            trap_ack  = 1'b0;
            if (mem_read || mem_write) begin
                if (!i_or_d) begin
                    mem_ready = (fw_left == 0);
                    if (fw_left > 0) fw_left--;
                end else begin
                    mem_ready = (dw_left == 0);
                    if (dw_left > 0) dw_left--;
                end
            end
            if (trap) begin
                trap_ack = (ack_left == 0);
                if (ack_left > 0) ack_left--;
            end
            #4;
            if ($isunknown(outs_flat())) saw_x = 1'b1;
            if (instr_done) begin n_done++; done_cyc = cyc; done = 1'b1; end
            if (reg_write) begin
                n_regw++; regw_cyc = cyc;
                regw_alu = 32'(alu_op); regw_dst = reg_dst; regw_m2r = mem2reg;
            end
            if (mem_write) n_memw++;
            if (pc_write)  n_pcw++;
            if (ir_write)  n_irw++;
            if (pc_write_cond) begin n_pcwc++; br_ne = branch_ne; br_src = pc_source; end
            if (mem_read && i_or_d) n_drd++;
            if (trap) begin
                n_trap++;
                if (trap_ack) begin done = 1'b1; done_cyc = cyc; end
            end
            if (cyc == fw + 3) ext_exec = ext_op;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        trap_ack  = 1'b0;

        check({name, ".latency"},   done_cyc, exp_lat);
        check({name, ".no_x"},      saw_x, 1'b0);
        check({name, ".to_fetch"},  state, S_FETCH);
        check({name, ".ir_write"},  n_irw, 1);
        check({name, ".pc_write"},  n_pcw, (k == K_J) ? 2 : 1);
        check({name, ".done_cnt"},  n_done, ill_trap ? 0 : 1);
        check({name, ".reg_write"}, n_regw, writes_reg ? 1 : 0);
        check({name, ".mem_write"}, n_memw, (k == K_SW) ? dw + 1 : 0);
        check({name, ".data_read"}, n_drd, (k == K_LW) ? dw + 1 : 0);
        check({name, ".pcw_cond"},  n_pcwc, (k == K_BR) ? 1 : 0);
        check({name, ".trap_cyc"},  n_trap, ill_trap ? ack_delay + 1 : 0);
        if (writes_reg) begin
            check({name, ".wb_cycle"}, regw_cyc, exp_lat);
            check({name, ".mem2reg"},  regw_m2r, (k == K_LW));
            check({name, ".reg_dst"},  regw_dst, (k == K_R));
            if (k != K_LW) check({name, ".alu_op"}, regw_alu, 32'(exp_alu(op, fn)));
        end
        if (k == K_BR) begin
            check({name, ".branch_ne"}, br_ne, (op == OP_BNE));
            check({name, ".pc_source"}, br_src, 2'b01);
        end
        if (k == K_I || k == K_LW || k == K_SW) begin
            check({name, ".ext_op"}, ext_exec, (op != OP_ORI));
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0; trap_ack = 1'b0;

        // Reset: everything low, including across a rising edge
        #3;
        check("reset.outputs", outs_flat(), 32'h0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #1;
        check("reset.edge_outputs", outs_flat(), 32'h0);
        #2 rst_n = 1'b1;
        #1;
        check("release.before_edge", mem_read, 1'b0);
        @(posedge clk); #1;
        check("release.fetch_read", mem_read, 1'b1);
        mem_ready = 1'b0;

        // Directed instructions
        run_instr("add",        OP_RTYPE, FN_ADD, 0, 0, 0);
        run_instr("lw_wait2",   OP_LW,    6'h00,  0, 2, 0);
        run_instr("bne",        OP_BNE,   6'h11,  0, 0, 0);
        run_instr("beq",        OP_BEQ,   6'h00,  0, 0, 0);
        run_instr("ori",        OP_ORI,   6'h3F,  0, 0, 0);
        run_instr("slti",       OP_SLTI,  6'h00,  0, 0, 0);
        run_instr("op_3f",      6'h3F,    6'h00,  0, 0, 2);
        run_instr("bad_funct",  OP_RTYPE, 6'h3F,  0, 0, 1);
        run_instr("sw_waits",   OP_SW,    6'h00,  1, 1, 0);
        run_instr("jump",       OP_J,     6'h00,  2, 0, 0);
        run_instr("sll",        OP_RTYPE, FN_SLL, 0, 0, 0);

        // Reset asserted while MEM_WR is waiting on memory
        opcode = OP_SW; funct = '0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid.mem_write_before", mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.mem_write", mem_write, 1'b0);
        check("rst_mid.outputs",   outs_flat(), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #2;
        check("rst_mid.release_quiet", outs_flat(), 32'h0);
        @(posedge clk); #1;
        check("rst_mid.fetch_state", state, S_FETCH);
        check("rst_mid.fetch_read",  mem_read, 1'b1);
        run_instr("after_reset", OP_RTYPE, FN_SUB, 0, 0, 0);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            int         sel = $urandom_range(0, 19);
            logic [5:0] op;
            logic [5:0] fn  = 6'($urandom);
            case (sel)
                0:  begin op = OP_RTYPE; fn = FN_ADD;  end
                1:  begin op = OP_RTYPE; fn = FN_ADDU; end
                2:  begin op = OP_RTYPE; fn = FN_SUB;  end
                3:  begin op = OP_RTYPE; fn = FN_SUBU; end
                4:  begin op = OP_RTYPE; fn = FN_SLL;  end
                5:  begin op = OP_RTYPE; fn = FN_SRL;  end
                6:  begin op = OP_RTYPE; fn = FN_SLT;  end
                7:  begin op = OP_RTYPE; fn = FN_AND;  end
                8:  begin op = OP_RTYPE; fn = FN_OR;   end
                9:  op = OP_BEQ;
                10: op = OP_BNE;
                11: op = OP_SLTI;
                12: op = OP_ORI;
                13: op = OP_LUI;
                14: op = OP_LW;
                15: op = OP_SW;
                16: op = OP_J;
                17: op = OP_LW;
                18: op = 6'h30 + 6'($urandom_range(0, 7));
                default: begin op = OP_RTYPE; fn = 6'h30 + 6'($urandom_range(0, 7)); end
            endcase
            run_instr($sformatf("rnd%0d", i), op, fn,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
